// File: rtl/key_pkg.sv
// Shared defaults and width helper for the multi-channel key debouncer.
// Optional long-press/repeat logic is enabled by KEY_DEBOUNCE_LONG_PRESS_EN.
package key_pkg;

    localparam int KEY_N            = 5;
    localparam int KEY_CLK_DIV      = 1000;
    localparam int KEY_STABLE_CNT   = 20;
    localparam int KEY_LONG_TICKS   = 1000;
    localparam int KEY_REPEAT_TICKS = 200;

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int key_clog2(input int v);
        int w;
        w = 0;
        for (int x = v - 1; x > 0; x = x >> 1) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key channel: 2-flop synchroniser, tick-qualified stability
// counter, accepted level and one-cycle press/release pulses.
// With KEY_DEBOUNCE_LONG_PRESS_EN defined a hold counter produces long/repeat
// pulses; otherwise key_long is tied low.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int STABLE_CNT   = KEY_STABLE_CNT,
    parameter int ACTIVE_LOW   = 0,
    parameter int LONG_TICKS   = KEY_LONG_TICKS,
    parameter int REPEAT_TICKS = KEY_REPEAT_TICKS
) (
    input  logic clk1M,
    input  logic rst,
    input  logic tick,
    input  logic key_raw,
    output logic key_state,
    output logic key_pulse,
    output logic key_release,
    output logic key_long
);

    localparam int   CNT_W    = key_clog2(STABLE_CNT);
    // Raw level that means "not pressed"; the synchroniser resets to it so the
    // normalised sample reads as released straight out of reset.
    localparam logic IDLE_RAW = (ACTIVE_LOW != 0);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic             pulse_q, pulse_d;
    logic             release_q, release_d;
    logic             sample;

    assign sample = sync2_q ^ IDLE_RAW;

    // Next-state: synchronise, count consecutive differing ticks, accept level.
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        if (tick) begin
            if (sample == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(STABLE_CNT - 1)) begin
                state_d = sample;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d   = state_d & ~state_q;
        release_d = ~state_d & state_q;
    end

    // State registers; reset discards pending counts and suppresses pulses.
    always_ff @(posedge clk1M) begin
        if (rst) begin
            sync1_q   <= IDLE_RAW;
            sync2_q   <= IDLE_RAW;
            cnt_q     <= '0;
            state_q   <= 1'b0;
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            release_q <= release_d;
        end
    end

    assign key_state   = state_q;
    assign key_pulse   = pulse_q;
    assign key_release = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int HOLD_W = key_clog2(LONG_TICKS + 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // Hold counter only advances on ticks where the key was and stays pressed,
    // so the accepting tick never counts and key_long cannot meet key_pulse.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!state_d) begin
            hold_d = '0;
        end else if (tick && state_q) begin
            if (hold_q == HOLD_W'(LONG_TICKS - 1)) begin
                long_d = 1'b1;
                hold_d = HOLD_W'(LONG_TICKS - REPEAT_TICKS);
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    // Hold counter and long-pulse registers.
    always_ff @(posedge clk1M) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign key_long = long_q;
`else
    localparam int long_cfg_unused = LONG_TICKS + REPEAT_TICKS;
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer on clk1M with a shared internal sample tick.
// KEY_DEBOUNCE_LONG_PRESS_EN enables per-channel long-press/repeat pulses.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N            = KEY_N,
    parameter int CLK_DIV      = KEY_CLK_DIV,
    parameter int STABLE_CNT   = KEY_STABLE_CNT,
    parameter int ACTIVE_LOW   = 0,
    parameter int LONG_TICKS   = KEY_LONG_TICKS,
    parameter int REPEAT_TICKS = KEY_REPEAT_TICKS
) (
    input  logic         clk1M,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_state,
    output logic [N-1:0] key_pulse,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_long
);

    localparam int DIV_W = key_clog2(CLK_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    // Tick on the last count of each period; CLK_DIV=1 ticks every cycle.
    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    // Divider next-state: wrap to zero on the tick cycle.
    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Divider register.
    always_ff @(posedge clk1M) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        key_debounce_ch #(
            .STABLE_CNT   (STABLE_CNT),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_ch (
            .clk1M       (clk1M),
            .rst         (rst),
            .tick        (tick),
            .key_raw     (key[i]),
            .key_state   (key_state[i]),
            .key_pulse   (key_pulse[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench for key_debounce_multi (N=2, CLK_DIV=4, STABLE_CNT=3).
// Long-press checks are active when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module tb_key_debounce_multi;

    localparam int DIV = 4;
    localparam int SC  = 3;
    localparam int LT  = 5;
    localparam int RT  = 2;

    logic       clk1M = 1'b0;
    logic       rst   = 1'b1;
    logic [1:0] key    = 2'b00;
    logic [1:0] key_al = 2'b11;
    logic [1:0] key_state, key_pulse, key_release, key_long;
    logic [1:0] al_state, al_pulse, al_release, al_long;

    int checks = 0;
    int errors = 0;

    // Reference model: level accepted once SC consecutive tick samples differ.
    int         m_n;
    logic [1:0] m_h0, m_h1;
    logic [1:0] m_st, m_pulse, m_rel, m_long;
    int         m_run  [2];
    int         m_held [2];

    always #5 clk1M = ~clk1M;

    key_debounce_multi #(
        .N(2), .CLK_DIV(DIV), .STABLE_CNT(SC), .ACTIVE_LOW(0),
        .LONG_TICKS(LT), .REPEAT_TICKS(RT)
    ) u_dut (
        .clk1M(clk1M), .rst(rst), .key(key),
        .key_state(key_state), .key_pulse(key_pulse),
        .key_release(key_release), .key_long(key_long)
    );

    key_debounce_multi #(
        .N(2), .CLK_DIV(DIV), .STABLE_CNT(SC), .ACTIVE_LOW(1),
        .LONG_TICKS(LT), .REPEAT_TICKS(RT)
    ) u_al (
        .clk1M(clk1M), .rst(rst), .key(key_al),
        .key_state(al_state), .key_pulse(al_pulse),
        .key_release(al_release), .key_long(al_long)
    );

    // One clock edge: advance the model with the inputs the DUT sampled, then
    // settle 1 time unit past the edge before anything is compared.
    task automatic step();
        logic [1:0] smp;
        logic       old;
        bit         tk;
        @(posedge clk1M);
        if (rst) begin
            m_n = 0; m_h0 = '0; m_h1 = '0; m_st = '0;
            m_pulse = '0; m_rel = '0; m_long = '0;
            for (int c = 0; c < 2; c++) begin m_run[c] = 0; m_held[c] = 0; end
        end else begin
            smp = m_h1;                       // key as seen two edges earlier
            tk  = ((m_n % DIV) == DIV - 1);
            m_n++;
            m_h1 = m_h0;
            m_h0 = key;
            m_pulse = '0; m_rel = '0; m_long = '0;
            for (int c = 0; c < 2; c++) begin
                old = m_st[c];
                if (tk) begin
                    if (smp[c] !== m_st[c]) begin
                        m_run[c]++;
                        if (m_run[c] == SC) begin
                            m_st[c]  = smp[c];
                            m_run[c] = 0;
                            if (smp[c]) m_pulse[c] = 1'b1;
                            else        m_rel[c]   = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
                    if (old && m_st[c]) begin
                        m_held[c]++;
                        if (m_held[c] >= LT && ((m_held[c] - LT) % RT) == 0)
                            m_long[c] = 1'b1;
                    end
`endif
                end
                if (!m_st[c]) m_held[c] = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        int lat, np;
        rst = 1'b1; key = 2'b11;
        repeat (10) begin
            step();
            checks++;
            if ({key_state, key_pulse, key_release, key_long, al_state, al_pulse, al_release, al_long} !== 16'h0) begin
                errors++;
                if (errors < 30) $display("FAIL reset_outputs t=%0t got %b exp 0", $time,
                    {key_state, key_pulse, key_release, key_long, al_state, al_pulse, al_release, al_long});
            end
        end
        rst = 1'b0; lat = -1; np = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            checks++;
            if ({key_state, key_pulse, key_release, key_long} !== {m_st, m_pulse, m_rel, m_long}) begin
                errors++;
                if (errors < 30) $display("FAIL reset_model t=%0t got %b exp %b", $time,
                    {key_state, key_pulse, key_release, key_long}, {m_st, m_pulse, m_rel, m_long});
            end
            if (key_pulse != 2'b00) np++;
            if (key_pulse == 2'b11 && lat < 0) lat = k;
        end
        checks++;
        if (lat < 11 || lat > 14 || np != 1) begin
            errors++;
            $display("FAIL reset_repress got lat=%0d pulses=%0d exp lat 11..14 pulses 1", lat, np);
        end
        key = 2'b00;
        repeat (30) step();
    endtask

    task automatic test_press_release();
        int lat, np;
        for (int ph = 0; ph < 2; ph++) begin
            key[0] = (ph == 0);
            lat = -1; np = 0;
            for (int k = 1; k <= 40; k++) begin
                step();
                checks++;
                if ({key_state, key_pulse, key_release, key_long} !== {m_st, m_pulse, m_rel, m_long}) begin
                    errors++;
                    if (errors < 30) $display("FAIL press_model t=%0t got %b exp %b", $time,
                        {key_state, key_pulse, key_release, key_long}, {m_st, m_pulse, m_rel, m_long});
                end
                if ((ph == 0 ? key_pulse[0] : key_release[0]) === 1'b1) begin
                    np++;
                    if (lat < 0) lat = k;
                end
            end
            checks++;
            if (lat < 11 || lat > 14 || np != 1 || key_state[0] !== (ph == 0)) begin
                errors++;
                $display("FAIL press_release_%0d got lat=%0d pulses=%0d state=%b exp lat 11..14 pulses 1 state %0d",
                    ph, lat, np, key_state[0], (ph == 0));
            end
        end
    endtask

    task automatic test_bounce();
        int np;
        np = 0;
        repeat (5) begin
            for (int k = 0; k < 12; k++) begin
                key[0] = (k < 8);
                step();
                checks++;
                if ({key_state, key_pulse, key_release, key_long} !== {m_st, m_pulse, m_rel, m_long}) begin
                    errors++;
                    if (errors < 30) $display("FAIL bounce_model t=%0t got %b exp %b", $time,
                        {key_state, key_pulse, key_release, key_long}, {m_st, m_pulse, m_rel, m_long});
                end
                if (key_state[0] || key_pulse[0] || key_release[0]) np++;
            end
        end
        checks++;
        if (np != 0) begin
            errors++;
            $display("FAIL bounce_reject got %0d active cycles exp 0", np);
        end
        key[0] = 1'b1; np = 0;
        repeat (30) begin
            step();
            if (key_pulse[0]) np++;
        end
        checks++;
        if (np != 1 || key_state[0] !== 1'b1) begin
            errors++;
            $display("FAIL bounce_settle got pulses=%0d state=%b exp pulses 1 state 1", np, key_state[0]);
        end
        key[0] = 1'b0;
        repeat (30) step();
    endtask

    task automatic test_independence();
        int p0, p1, n0, n1, r0, r1;
        p0 = -1; p1 = -1; n0 = 0; n1 = 0; r0 = 0; r1 = 0;
        key = 2'b01;
        for (int k = 1; k <= 33; k++) begin
            if (k == 4) key = 2'b11;
            step();
            checks++;
            if ({key_state, key_pulse, key_release, key_long} !== {m_st, m_pulse, m_rel, m_long}) begin
                errors++;
                if (errors < 30) $display("FAIL indep_model t=%0t got %b exp %b", $time,
                    {key_state, key_pulse, key_release, key_long}, {m_st, m_pulse, m_rel, m_long});
            end
            if (key_pulse[0]) begin n0++; if (p0 < 0) p0 = k; end
            if (key_pulse[1]) begin n1++; if (p1 < 0) p1 = k; end
        end
        checks++;
        if (n0 != 1 || n1 != 1 || p1 < p0) begin
            errors++;
            $display("FAIL indep_pulses got n0=%0d n1=%0d p0=%0d p1=%0d exp one each with p1>=p0", n0, n1, p0, p1);
        end
        key = 2'b01;
        repeat (30) begin
            step();
            if (key_release[0] || !key_state[0]) r0++;
            if (key_release[1]) r1++;
        end
        checks++;
        if (r0 != 0 || r1 != 1) begin
            errors++;
            $display("FAIL indep_release got ch0_disturb=%0d ch1_rel=%0d exp 0 and 1", r0, r1);
        end
        key = 2'b00;
        repeat (30) step();
    endtask

    task automatic test_active_low();
        int lat, np, bad;
        checks++;
        if (al_state !== 2'b00) begin
            errors++;
            $display("FAIL al_idle got %b exp 00", al_state);
        end
        key_al = 2'b01; lat = -1; np = 0; bad = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (al_pulse[1]) begin np++; if (lat < 0) lat = k; end
            if (al_pulse[0] || al_state[0]) bad++;
        end
        checks++;
        if (lat < 11 || lat > 14 || np != 1 || bad != 0 || al_state !== 2'b10) begin
            errors++;
            $display("FAIL al_press got lat=%0d pulses=%0d ch0=%0d state=%b exp lat 11..14 pulses 1 ch0 0 state 10",
                lat, np, bad, al_state);
        end
        key_al = 2'b11;
        repeat (30) step();
    endtask

    task automatic test_long();
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
        int r, nl, exp_at, bad;
        for (int pass = 0; pass < 2; pass++) begin
            key[0] = 1'b1; r = -1; nl = 0; bad = 0;
            for (int k = 1; k <= 70; k++) begin
                step();
                checks++;
                if ({key_state, key_pulse, key_release, key_long} !== {m_st, m_pulse, m_rel, m_long}) begin
                    errors++;
                    if (errors < 30) $display("FAIL long_model t=%0t got %b exp %b", $time,
                        {key_state, key_pulse, key_release, key_long}, {m_st, m_pulse, m_rel, m_long});
                end
                if (key_state[0] && r < 0) r = k;
                if (key_long[0]) begin
                    exp_at = r + LT * DIV + nl * RT * DIV;
                    if (r < 0 || k != exp_at || key_pulse[0]) bad++;
                    nl++;
                end
            end
            checks++;
            if (bad != 0 || nl != 1 + ((70 - r) - LT * DIV) / (RT * DIV)) begin
                errors++;
                $display("FAIL long_timing_%0d got rise=%0d longs=%0d misplaced=%0d", pass, r, nl, bad);
            end
            key[0] = 1'b0; nl = 0;
            repeat (40) begin
                step();
                if (key_long[0] && !key_state[0]) nl++;
            end
            checks++;
            if (nl != 0 || key_state[0] !== 1'b0) begin
                errors++;
                $display("FAIL long_stop got %0d longs after release state=%b exp 0", nl, key_state[0]);
            end
        end
`else
        int nl;
        key[0] = 1'b1; nl = 0;
        repeat (80) begin
            step();
            if (key_long != 2'b00) nl++;
        end
        checks++;
        if (nl != 0 || key_state[0] !== 1'b1) begin
            errors++;
            $display("FAIL long_disabled got %0d long cycles state=%b exp 0 and 1", nl, key_state[0]);
        end
        key[0] = 1'b0;
        repeat (30) step();
`endif
    endtask

    task automatic test_random();
        int hold;
        repeat (120) begin
            key  = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 20);
            rst  = ($urandom_range(0, 40) == 0);
            repeat (hold) begin
                step();
                rst = 1'b0;
                checks++;
                if ({key_state, key_pulse, key_release, key_long} !== {m_st, m_pulse, m_rel, m_long}) begin
                    errors++;
                    if (errors < 30) $display("FAIL random_model t=%0t got %b exp %b", $time,
                        {key_state, key_pulse, key_release, key_long}, {m_st, m_pulse, m_rel, m_long});
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_press_release();
        test_bounce();
        test_independence();
        test_active_low();
        test_long();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button debouncer. It is the successor to the two-sample, external-20ms-clock key filter.
- Runs entirely on clk1M and derives its own sample tick internally, so no second clock domain is needed.
- Per channel it provides a synchronised, counter-filtered stable level, plus one-cycle press and release pulses.
- Sits between the raw panel keys and the control FSMs, which consume the pulses.

Parameters:
N, 5, number of key channels
CLK_DIV, 1000, clk1M cycles per sample tick (1000 gives 1 ms); legal range >=1
STABLE_CNT, 20, consecutive ticks a new level must persist before it is accepted; legal range >=1
ACTIVE_LOW, 0, 1 means raw keys are active-low and are inverted after synchronisation
LONG_TICKS, 1000, ticks held before the first long/repeat pulse (LONG_PRESS_EN only)
REPEAT_TICKS, 200, ticks between repeat pulses while held (LONG_PRESS_EN only)

Ports:
clk1M  input  1  system clock, 1 MHz
rst  input  1  synchronous reset, active-high
key  input  N  raw asynchronous key inputs
key_state  output  N  debounced level, 1 = pressed
key_pulse  output  N  one-cycle pulse on accepted press
key_release  output  N  one-cycle pulse on accepted release
key_long  output  N  one-cycle long-press/repeat pulse (constant 0 without LONG_PRESS_EN)

Behaviour:
- Single clock domain: clk1M. Reset is synchronous and active-high.
- On rst:
  - tick counter = 0; all synchroniser flops = 0 (normalised, i.e. not pressed); all stable counters = 0.
  - key_state, key_pulse, key_release and key_long = 0.
- Synchroniser: 2-flop chain per channel. The normalised sample is sync2 XOR ACTIVE_LOW.
- Tick generator:
  - Counter runs 0..CLK_DIV-1; tick = 1 for exactly one cycle when counter == CLK_DIV-1, after which the counter wraps to 0.
  - CLK_DIV = 1 gives tick every cycle. Counter width is clog2(CLK_DIV), minimum 1.
- Per channel, on tick cycles only:
  - sample == key_state: cnt <= 0.
  - sample != key_state and cnt < STABLE_CNT-1: cnt <= cnt+1.
  - sample != key_state and cnt == STABLE_CNT-1: key_state <= sample, cnt <= 0.
- Non-tick cycles: cnt and key_state hold.
- Pulses:
  - key_pulse[i] is registered in the same edge as key_state[i] 0->1, and key_release[i] in the same edge as 1->0.
  - Each is therefore high for exactly one clk1M cycle, coincident with the first cycle of the new key_state. Both are 0 otherwise.
- Latency: from a clean input edge to the key_state change is 2 sync cycles plus STABLE_CNT ticks. That is, between 2+(STABLE_CNT-1)*CLK_DIV+1 and 2+STABLE_CNT*CLK_DIV cycles.
- Bounce: any tick sample that equals key_state clears cnt, so a glitch shorter than STABLE_CNT ticks is never accepted.
- Channels are fully independent. Simultaneous pulses on several channels in the same cycle are legal.
- Reset mid-operation:
  - Pending counts are discarded and no pulse is emitted on the reset edge.
  - A key held through reset is re-accepted as a fresh press (key_pulse) STABLE_CNT ticks after rst deasserts.

Optional Feature:
- Macro: KEY_DEBOUNCE_LONG_PRESS_EN.
- Defined: a per-channel hold counter, width clog2(LONG_TICKS+1), counts ticks while key_state = 1.
  - On reaching LONG_TICKS: key_long pulses for one cycle; the counter reloads to LONG_TICKS-REPEAT_TICKS, giving a pulse every REPEAT_TICKS ticks thereafter.
  - The counter clears when key_state = 0 or on rst.
  - key_long never coincides with key_pulse.
- Undefined: no hold counters are built, and key_long is tied to 0.

Decomposition:
- Package key_pkg:
  - default constants (KEY_N, KEY_CLK_DIV, KEY_STABLE_CNT, KEY_LONG_TICKS, KEY_REPEAT_TICKS);
  - a clog2 helper function for counter widths.
- Sub-module key_debounce_ch: one channel, containing sync, stable counter, state, pulses and the optional hold counter. It takes tick as an input.
- Top level: holds the shared tick generator and generate-instantiates N channels.

Test Plan (bench parameters N=2, CLK_DIV=4, STABLE_CNT=3, ACTIVE_LOW=0 unless noted):
1. Reset: key=2'b11 held with rst=1 for 10 cycles -> all outputs 0. After rst drops, key_pulse=2'b11 appears once, 11-14 cycles later.
2. Clean press/release: key[0] 0->1 -> a single one-cycle key_pulse[0] within 11-14 cycles, key_state[0]=1. Release after 40 cycles -> a single key_release[0] within 11-14 cycles.
3. Bounce: key[0] high for 8 cycles, low for 4, repeated 5 times -> key_state[0] stays 0 and no pulses. Then held high -> exactly one key_pulse[0].
4. Independence: key[1] rises 3 cycles after key[0] -> two separate single pulses, ordered by tick alignment, and key[1] activity has no effect on channel 0.
5. ACTIVE_LOW=1: key=2'b11 idle -> key_state=0. key[1] driven low -> key_pulse[1] within 11-14 cycles.
6. LONG_PRESS_EN with LONG_TICKS=5, REPEAT_TICKS=2: hold key[0] -> key_long[0] 5 ticks after key_state rises, then every 2 ticks. Release -> key_long stops and the hold counter clears.
